nexys_starship_monster_sched: RTL and testbench
===============================================

// Module: nexys_starship_monster_sched
// PURPOSE
//  Schedules monster arrivals at the ship's 4 terminals (0=N,1=E,2=S,3=W) while the game is in PLAY.
//  Spawns monsters on a pseudo-random timer, ages each active monster, clears monsters the player shoots,
//  and raises game_over when any monster outlives its timeout. Sits beside the game FSM:
//  it consumes q_Play and feeds game_over back; the VGA and score logic read its outputs.
// PARAMETERS
//  SPAWN_INTERVAL   50       ticks between spawn attempts (>=2)
//  MONSTER_TIMEOUT  200      ticks a monster may stay alive before game over (>=2)
//  LFSR_SEED        16'hACE1 reset value of the spawn LFSR (nonzero)
//  TIMER_W          16       width of survive_ticks
// PORTS
//  Clk             in   1        system clock
//  Reset           in   1        synchronous, active-high reset
//  q_Play          in   1        game FSM is in PLAY
//  tick            in   1        1-cycle game-time enable (frame/ms strobe)
//  kill_req        in   4        1-cycle per-terminal "player fired at terminal i"
//  monster_active  out  4        bit i = monster present at terminal i
//  spawn_pulse     out  1        1-cycle pulse, cycle after a monster is placed
//  game_over       out  1        level; held high in DONE
//  kill_count      out  8        monsters killed this game, saturates at 255
//  survive_ticks   out  TIMER_W  ticks spent in RUN this game, saturates at all-ones
// BEHAVIOUR
//  - Reset (sync, on Clk edge): state=IDLE, all outputs 0, counters 0, LFSR=LFSR_SEED.
//  - LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11, advances every Clk regardless of state.
//  - States IDLE, RUN, DONE (encoding free).
//    IDLE: outputs/counters held at 0; q_Play=1 -> RUN next cycle; counters already 0 on entry.
//    RUN: q_Play=0 -> IDLE next cycle, all state cleared (highest priority after Reset).
//         any age timeout -> DONE.
//    DONE: game_over=1, monster_active=0, kill_count/survive_ticks frozen;
//          q_Play=0 -> IDLE next cycle (game_over drops in IDLE).
//  - RUN, on tick: survive_ticks+1 (saturating); spawn_cnt+1; ages of active terminals +1.
//  - Spawn: on tick with spawn_cnt==SPAWN_INTERVAL-1, spawn_cnt<=0 and start=LFSR[1:0];
//    place at the first free terminal scanning start, start+1, ... mod 4 (pre-cycle occupancy);
//    new monster age=0, bit set next cycle, spawn_pulse=1 that same next cycle.
//    All 4 busy -> no spawn, no pulse, spawn_cnt still resets.
//  - Timeout: on tick, active terminal with age==MONSTER_TIMEOUT-1 -> DONE; game_over=1 next cycle.
//  - Kill: kill_req[i]=1 in RUN with bit i set -> bit i cleared next cycle, age_i<=0,
//    kill_count+1 (saturating). Each set bit counts separately.
//  - kill_req on an inactive terminal, or outside RUN: ignored.
//  - Same cycle kill + timeout on one terminal: kill wins, no game over from it.
//    Timeout on a different terminal still ends the game; kills that cycle still count.
//  - Same cycle kill + spawn: spawn sees pre-cycle occupancy, so it never lands on the killed terminal.
//  - No tick: only kill processing and q_Play exit occur.
// TESTING
//  1 Reset, q_Play=1, tick every cycle, LFSR[1:0]=2 at spawn
//    -> monster_active=4'b0100 and spawn_pulse=1 on the cycle after tick 50.
//  2 Spawn at T, no kills -> game_over=1 the cycle after the 200th tick after spawn; state DONE.
//  3 Active on 0 and 2, kill_req=4'b0101 -> monster_active=0 next cycle, kill_count=2.
//  4 All 4 active at spawn tick -> no spawn_pulse, occupancy unchanged.
//    Kill same-cycle as timeout tick -> no game_over.
//  5 q_Play drops mid-RUN with 3 active -> next cycle all outputs 0.
//    q_Play high again -> survive_ticks restarts from 0.
//  6 Reset asserted in DONE -> next cycle game_over=0, kill_count=0, LFSR=16'hACE1.

Source files
------------

// File: rtl/nexys_starship_monster_sched.sv
// Monster scheduler for the starship game: spawns, ages and clears monsters at the
// four terminals while the game is in PLAY, and flags game over on any timeout.
module nexys_starship_monster_sched #(
    parameter int          SPAWN_INTERVAL  = 50,
    parameter int          MONSTER_TIMEOUT = 200,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1,
    parameter int          TIMER_W         = 16
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               q_Play,
    input  logic               tick,
    input  logic [3:0]         kill_req,
    output logic [3:0]         monster_active,
    output logic               spawn_pulse,
    output logic               game_over,
    output logic [7:0]         kill_count,
    output logic [TIMER_W-1:0] survive_ticks
);

    localparam int SC_W  = $clog2(SPAWN_INTERVAL);
    localparam int AGE_W = $clog2(MONSTER_TIMEOUT);
    localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(SPAWN_INTERVAL - 1);
    localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(MONSTER_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [15:0]      lfsr;
    logic [SC_W-1:0]  spawn_cnt;
    logic [AGE_W-1:0] age [4];
    logic [3:0]       kills, expire, spawn_mask;
    logic             timeout, spawn_due, spawn_ok;
    logic [1:0]       spawn_idx, cand;
    logic [8:0]       kill_total;

    // Galois LFSR, x^16+x^14+x^13+x^11; free-running so spawn terminals vary with play timing.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {1'b0, lfsr[15:1]} ^ ({16{lfsr[0]}} & 16'b1011_0100_0000_0000);
        end
    end

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        kills  = '0;
        expire = '0;
        if (state == RUN) begin
            kills = kill_req & monster_active;
            for (int i = 0; i < 4; i++) begin
                expire[i] = tick && monster_active[i] && !kill_req[i] && (age[i] == AGE_LAST);
            end
        end
    end

    assign timeout   = |expire;
    assign spawn_due = (state == RUN) && tick && (spawn_cnt == SC_LAST);

    // Scan from the LFSR start terminal; the lowest offset that is free wins.
    always_comb begin
        spawn_ok  = 1'b0;
        spawn_idx = '0;
        cand      = '0;
        for (int k = 3; k >= 0; k--) begin
            cand = lfsr[1:0] + 2'(k);
            if (!monster_active[cand]) begin
                spawn_ok  = 1'b1;
                spawn_idx = cand;
            end
        end
    end

    assign spawn_mask = (spawn_due && spawn_ok) ? (4'b0001 << spawn_idx) : 4'b0000;
    assign kill_total = {1'b0, kill_count} + 9'(kills[0]) + 9'(kills[1])
                      + 9'(kills[2]) + 9'(kills[3]);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (q_Play) state_next = RUN;
            RUN:     if (!q_Play) state_next = IDLE;
                     else if (timeout) state_next = DONE;
            DONE:    if (!q_Play) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        game_over = (state == DONE);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset || state_next == IDLE) begin
            monster_active <= '0;
            spawn_pulse    <= 1'b0;
            kill_count     <= '0;
            survive_ticks  <= '0;
            spawn_cnt      <= '0;
            // NOTE: the age array is only four small registers, so it is cleared like any other state.
            for (int i = 0; i < 4; i++) age[i] <= '0;
        end else begin
            spawn_pulse <= 1'b0;
            if (state == RUN) begin
                kill_count <= (kill_total > 9'd255) ? 8'hFF : kill_total[7:0];
                for (int i = 0; i < 4; i++) begin
                    if (kills[i]) age[i] <= '0;
                    else if (tick && monster_active[i]) age[i] <= age[i] + AGE_W'(1);
                end
                if (tick) begin
                    if (survive_ticks != '1) survive_ticks <= survive_ticks + TIMER_W'(1);
                    spawn_cnt <= spawn_due ? '0 : spawn_cnt + SC_W'(1);
                end
                // A timeout blanks the board; otherwise apply kills and any new arrival.
                if (timeout) begin
                    monster_active <= '0;
                end else begin
                    monster_active <= (monster_active & ~kills) | spawn_mask;
                    if (spawn_due && spawn_ok) begin
                        age[spawn_idx] <= '0;
                        spawn_pulse    <= 1'b1;
                    end
                end
            end else if (state == DONE) begin
                monster_active <= '0;
            end
        end
    end

endmodule

// File: tb/tb_nexys_starship_monster_sched.sv
// Randomized scoreboard bench for the monster scheduler against a per-monster behavioural model.
module tb_nexys_starship_monster_sched;

    localparam int SI = 3;
    localparam int TO = 16;
    localparam int TW = 8;
    localparam int N_RANDOM_END = 3003;
    localparam int N_SAT_END    = 4403;
    localparam int N_TOTAL      = 4433;
    localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;

    logic          Clk;
    logic          Reset;
    logic          q_Play;
    logic          tick;
    logic [3:0]    kill_req;
    logic [3:0]    monster_active;
    logic          spawn_pulse;
    logic          game_over;
    logic [7:0]    kill_count;
    logic [TW-1:0] survive_ticks;

    nexys_starship_monster_sched #(
        .SPAWN_INTERVAL (SI),
        .MONSTER_TIMEOUT(TO),
        .LFSR_SEED      (16'hACE1),
        .TIMER_W        (TW)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .q_Play        (q_Play),
        .tick          (tick),
        .kill_req      (kill_req),
        .monster_active(monster_active),
        .spawn_pulse   (spawn_pulse),
        .game_over     (game_over),
        .kill_count    (kill_count),
        .survive_ticks (survive_ticks)
    );

    typedef struct {
        logic [3:0]    act;
        logic          pulse;
        logic          over;
        logic [7:0]    kc;
        logic [TW-1:0] st;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Model: each terminal holds its monster's age, or -1 when empty.
    int          m_age [4];
    int          m_mode;
    int          m_kills;
    int          m_surv;
    int          m_sc;
    bit          m_pulse;
    logic [15:0] m_lfsr;

    initial begin
        Clk = 1'b1;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_age[i] = -1;
        m_mode  = M_IDLE;
        m_kills = 0;
        m_surv  = 0;
        m_sc    = 0;
        m_pulse = 0;
    endtask

    task automatic model_step(input bit rst, input bit qp, input bit tk, input logic [3:0] kr);
        bit pre [4];
        bit killed [4];
        bit expired;
        int start, slot;
        if (rst) begin
            model_clear();
            m_lfsr = 16'hACE1;
        end else begin
            m_pulse = 0;
            case (m_mode)
                M_IDLE: if (qp) m_mode = M_RUN;
                M_RUN: begin
                    if (!qp) begin
                        model_clear();
                    end else begin
                        expired = 0;
                        for (int i = 0; i < 4; i++) begin
                            pre[i]    = (m_age[i] >= 0);
                            killed[i] = kr[i] && pre[i];
                            if (tk && pre[i] && !killed[i] && m_age[i] == TO - 1) expired = 1;
                        end
                        for (int i = 0; i < 4; i++) begin
                            if (killed[i]) begin
                                if (m_kills < 255) m_kills++;
                                m_age[i] = -1;
                            end
                        end
                        if (tk) begin
                            if (m_surv < (1 << TW) - 1) m_surv++;
                            m_sc++;
                            for (int i = 0; i < 4; i++) if (m_age[i] >= 0) m_age[i]++;
                        end
                        if (expired) begin
                            m_mode = M_DONE;
                            for (int i = 0; i < 4; i++) m_age[i] = -1;
                        end else if (tk && m_sc == SI) begin
                            m_sc  = 0;
                            start = int'(m_lfsr[1:0]);
                            slot  = -1;
                            for (int k = 0; k < 4; k++)
                                if (slot < 0 && !pre[(start + k) % 4]) slot = (start + k) % 4;
                            if (slot >= 0) begin
                                m_age[slot] = 0;
                                m_pulse     = 1;
                            end
                        end
                    end
                end
                default: if (!qp) model_clear();
            endcase
            m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
        end
    endtask

    function automatic exp_t model_outputs();
        exp_t e;
        e.act = '0;
        for (int i = 0; i < 4; i++) e.act[i] = (m_age[i] >= 0);
        e.pulse = m_pulse;
        e.over  = (m_mode == M_DONE);
        e.kc    = 8'(m_kills);
        e.st    = TW'(m_surv);
        return e;
    endfunction

    // Driver: random play, then a saturation run with constant kills, then idle noise.
    initial begin
        bit         rst, qp, tk;
        logic [3:0] kr;
        Reset = 1'b1; q_Play = 1'b0; tick = 1'b0; kill_req = '0;
        for (int c = 0; c < N_TOTAL; c++) begin
            @(negedge Clk);
            kr = '0;
            if (c < 3) begin
                rst = 1; qp = ($urandom_range(0, 1) == 1); tk = 1; kr = 4'(($urandom));
            end else if (c < N_RANDOM_END) begin
                rst = (m_mode == M_DONE && $urandom_range(0, 3) == 0) || ($urandom_range(0, 499) == 0);
                qp  = ($urandom_range(0, 99) >= 3);
                tk  = ($urandom_range(0, 9) < 7);
                for (int i = 0; i < 4; i++) begin
                    if ($urandom_range(0, 49) == 0) kr[i] = 1'b1;
                    if (tk && m_mode == M_RUN && m_age[i] == TO - 1 && $urandom_range(0, 1) == 1)
                        kr[i] = 1'b1;
                end
            end else if (c < N_SAT_END) begin
                rst = (c == N_RANDOM_END); qp = (c != N_RANDOM_END + 1); tk = 1; kr = 4'hF;
            end else begin
                rst = 0; qp = 0; tk = ($urandom_range(0, 1) == 1); kr = 4'(($urandom));
            end
            Reset = rst; q_Play = qp; tick = tk; kill_req = kr;
            model_step(rst, qp, tk, kr);
            sb_q.push_back(model_outputs());
        end
        @(posedge Clk);
        #2;
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Monitor: one expected record per clock edge, compared #1 after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("monster_active", 32'(monster_active), 32'(e.act));
                check("spawn_pulse",    32'(spawn_pulse),    32'(e.pulse));
                check("game_over",      32'(game_over),      32'(e.over));
                check("kill_count",     32'(kill_count),     32'(e.kc));
                check("survive_ticks",  32'(survive_ticks),  32'(e.st));
            end
        end
    end

endmodule
